// File: rtl/alu32_pkg.sv
// Shared ALU32 definitions: function codes and checker FSM state encoding.
package alu32_pkg;

  typedef logic [10:0] op_t;

  localparam op_t OP_ADD  = 11'h020;
  localparam op_t OP_ADDU = 11'h021;
  localparam op_t OP_SUB  = 11'h022;
  localparam op_t OP_SUBU = 11'h023;
  localparam op_t OP_AND  = 11'h024;
  localparam op_t OP_OR   = 11'h025;
  localparam op_t OP_XOR  = 11'h026;
  localparam op_t OP_NOR  = 11'h027;
  localparam op_t OP_SLT  = 11'h02A;
  localparam op_t OP_SLTU = 11'h02B;
  localparam op_t OP_SLL  = 11'h004;
  localparam op_t OP_SRL  = 11'h006;
  localparam op_t OP_SRA  = 11'h007;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_HALT = 2'd2;

endpackage

// File: rtl/alu32_ref_model.sv
// Combinational golden ALU32: expected result and flags for one operation.
// o_sup is low for function codes the checker does not model.
module alu32_ref_model
  import alu32_pkg::*;
(
  input  logic [10:0] i_op,
  input  logic [31:0] i_in0,
  input  logic [31:0] i_in1,
  output logic [31:0] o_out,
  output logic        o_carry,
  output logic        o_ovf,
  output logic        o_zero,
  output logic        o_sup
);

  logic [32:0] w_sum;
  logic [31:0] w_diff;

  assign w_sum  = {1'b0, i_in0} + {1'b0, i_in1};
  assign w_diff = i_in0 - i_in1;

  always_comb begin
    o_out   = '0;
    o_carry = 1'b0;
    o_ovf   = 1'b0;
    o_sup   = 1'b1;
    case (i_op)
      OP_ADD, OP_ADDU: begin
        o_out   = w_sum[31:0];
        o_carry = w_sum[32];
        o_ovf   = (i_op == OP_ADD) && (i_in0[31] == i_in1[31]) && (w_sum[31] != i_in0[31]);
      end
      OP_SUB, OP_SUBU: begin
        // carryout reports a borrow for subtraction
        o_out   = w_diff;
        o_carry = (i_in0 < i_in1);
        o_ovf   = (i_op == OP_SUB) && (i_in0[31] != i_in1[31]) && (w_diff[31] != i_in0[31]);
      end
      OP_AND:  o_out = i_in0 & i_in1;
      OP_OR:   o_out = i_in0 | i_in1;
      OP_XOR:  o_out = i_in0 ^ i_in1;
      OP_NOR:  o_out = ~(i_in0 | i_in1);
      OP_SLT:  o_out = {31'b0, ($signed(i_in0) < $signed(i_in1))};
      OP_SLTU: o_out = {31'b0, (i_in0 < i_in1)};
      OP_SLL:  o_out = i_in0 << i_in1[4:0];
      OP_SRL:  o_out = i_in0 >> i_in1[4:0];
      OP_SRA:  o_out = $signed(i_in0) >>> i_in1[4:0];
      default: o_sup = 1'b0;
    endcase
  end

  assign o_zero = (o_out == 32'd0);

endmodule

// File: rtl/alu32_checker.sv
// In-line ALU32 result checker: two-stage pipeline (capture, compare) then count/report.
// err_pulse and counters update two cycles after an accepted in_valid.
module alu32_checker
  import alu32_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter bit FLAG_CHECK = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop_on_err,
  input  logic             in_valid,
  input  logic [10:0]      op,
  input  logic [31:0]      in0,
  input  logic [31:0]      in1,
  input  logic [31:0]      dut_out,
  input  logic             dut_carryout,
  input  logic             dut_overflow,
  input  logic             dut_zero,
  output logic             busy,
  output logic             halted,
  output logic             err_pulse,
  output logic [CNT_W-1:0] check_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] unsup_count,
  output logic [10:0]      fail_op,
  output logic [31:0]      fail_in0,
  output logic [31:0]      fail_in1,
  output logic [31:0]      fail_got,
  output logic [31:0]      fail_exp,
  output logic             fail_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic             r_s1_vld, r_s1_c, r_s1_v, r_s1_z;
  logic [10:0]      r_s1_op;
  logic [31:0]      r_s1_in0, r_s1_in1, r_s1_out;
  logic             r_s2_vld, r_s2_sup, r_s2_mis;
  logic [10:0]      r_s2_op;
  logic [31:0]      r_s2_in0, r_s2_in1, r_s2_got, r_s2_exp;
  logic             r_err_pulse, r_fail_valid;
  logic [CNT_W-1:0] r_chk_cnt, r_err_cnt, r_uns_cnt;
  logic [10:0]      r_fail_op;
  logic [31:0]      r_fail_in0, r_fail_in1, r_fail_got, r_fail_exp;

  logic [31:0]      w_exp_out;
  logic             w_exp_c, w_exp_v, w_exp_z, w_sup;
  logic             w_accept, w_mis, w_s2_err;

  alu32_ref_model u_ref (
    .i_op    (r_s1_op),
    .i_in0   (r_s1_in0),
    .i_in1   (r_s1_in1),
    .o_out   (w_exp_out),
    .o_carry (w_exp_c),
    .o_ovf   (w_exp_v),
    .o_zero  (w_exp_z),
    .o_sup   (w_sup)
  );

  assign w_accept = (r_state == ST_RUN) && in_valid;
  assign w_mis    = (r_s1_out != w_exp_out) ||
                    (FLAG_CHECK && ({r_s1_c, r_s1_v, r_s1_z} != {w_exp_c, w_exp_v, w_exp_z}));
  assign w_s2_err = r_s2_vld && r_s2_sup && r_s2_mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_s1_vld     <= 1'b0;
      r_s1_op      <= '0;
      r_s1_in0     <= '0;
      r_s1_in1     <= '0;
      r_s1_out     <= '0;
      r_s1_c       <= 1'b0;
      r_s1_v       <= 1'b0;
      r_s1_z       <= 1'b0;
      r_s2_vld     <= 1'b0;
      r_s2_sup     <= 1'b0;
      r_s2_mis     <= 1'b0;
      r_s2_op      <= '0;
      r_s2_in0     <= '0;
      r_s2_in1     <= '0;
      r_s2_got     <= '0;
      r_s2_exp     <= '0;
      r_err_pulse  <= 1'b0;
      r_chk_cnt    <= '0;
      r_err_cnt    <= '0;
      r_uns_cnt    <= '0;
      r_fail_valid <= 1'b0;
      r_fail_op    <= '0;
      r_fail_in0   <= '0;
      r_fail_in1   <= '0;
      r_fail_got   <= '0;
      r_fail_exp   <= '0;
    end else if (start) begin
      // start outranks any result leaving stage 2 this cycle
      r_state      <= ST_RUN;
      r_s1_vld     <= 1'b0;
      r_s2_vld     <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_chk_cnt    <= '0;
      r_err_cnt    <= '0;
      r_uns_cnt    <= '0;
      r_fail_valid <= 1'b0;
      r_fail_op    <= '0;
      r_fail_in0   <= '0;
      r_fail_in1   <= '0;
      r_fail_got   <= '0;
      r_fail_exp   <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_op  <= op;
        r_s1_in0 <= in0;
        r_s1_in1 <= in1;
        r_s1_out <= dut_out;
        r_s1_c   <= dut_carryout;
        r_s1_v   <= dut_overflow;
        r_s1_z   <= dut_zero;
      end
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_sup <= w_sup;
        r_s2_mis <= w_mis;
        r_s2_op  <= r_s1_op;
        r_s2_in0 <= r_s1_in0;
        r_s2_in1 <= r_s1_in1;
        r_s2_got <= r_s1_out;
        r_s2_exp <= w_exp_out;
      end
      r_err_pulse <= w_s2_err;
      // in-flight work drains even after HALT, so counts stay exact
      if (r_s2_vld && r_s2_sup && (r_chk_cnt != CNT_MAX)) r_chk_cnt <= r_chk_cnt + 1'b1;
      if (r_s2_vld && !r_s2_sup && (r_uns_cnt != CNT_MAX)) r_uns_cnt <= r_uns_cnt + 1'b1;
      if (w_s2_err) begin
        if (r_err_cnt != CNT_MAX) r_err_cnt <= r_err_cnt + 1'b1;
        if (!r_fail_valid) begin
          r_fail_valid <= 1'b1;
          r_fail_op    <= r_s2_op;
          r_fail_in0   <= r_s2_in0;
          r_fail_in1   <= r_s2_in1;
          r_fail_got   <= r_s2_got;
          r_fail_exp   <= r_s2_exp;
        end
        if (stop_on_err && (r_state == ST_RUN)) r_state <= ST_HALT;
      end
    end
  end

  assign busy        = (r_state == ST_RUN);
  assign halted      = (r_state == ST_HALT);
  assign err_pulse   = r_err_pulse;
  assign check_count = r_chk_cnt;
  assign err_count   = r_err_cnt;
  assign unsup_count = r_uns_cnt;
  assign fail_valid  = r_fail_valid;
  assign fail_op     = r_fail_op;
  assign fail_in0    = r_fail_in0;
  assign fail_in1    = r_fail_in1;
  assign fail_got    = r_fail_got;
  assign fail_exp    = r_fail_exp;

endmodule

// File: tb/tb_alu32_checker.sv
// Bench for alu32_checker: directed corner cases plus a randomized run against an arithmetic reference.
module tb_alu32_checker;

  localparam int CW = 5;
  localparam logic [CW-1:0] CMAX = '1;
  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, stop_on_err = 1'b0, in_valid = 1'b0;
  logic [10:0]   op = '0;
  logic [31:0]   in0 = '0, in1 = '0, dut_out = '0;
  logic          dut_carryout = 1'b0, dut_overflow = 1'b0, dut_zero = 1'b0;
  logic          busy, halted, err_pulse, fail_valid;
  logic [CW-1:0] check_count, err_count, unsup_count;
  logic [10:0]   fail_op;
  logic [31:0]   fail_in0, fail_in1, fail_got, fail_exp;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu32_checker #(.CNT_W(CW), .FLAG_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .stop_on_err(stop_on_err), .in_valid(in_valid),
    .op(op), .in0(in0), .in1(in1), .dut_out(dut_out),
    .dut_carryout(dut_carryout), .dut_overflow(dut_overflow), .dut_zero(dut_zero),
    .busy(busy), .halted(halted), .err_pulse(err_pulse),
    .check_count(check_count), .err_count(err_count), .unsup_count(unsup_count),
    .fail_op(fail_op), .fail_in0(fail_in0), .fail_in1(fail_in1),
    .fail_got(fail_got), .fail_exp(fail_exp), .fail_valid(fail_valid)
  );

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        v;
    logic        z;
    logic        sup;
  } exp_t;

  typedef struct packed {
    logic        vld;
    logic        sup;
    logic        mis;
    logic [10:0] f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] got;
    logic [31:0] exp;
  } pend_t;

  // Reference ALU built from 64-bit integer arithmetic.
  function automatic exp_t model(input logic [10:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t            e;
    longint          sa, sb, sr;
    longint unsigned ua, ub;
    int              sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    sh = int'(b % 32);
    e = '0;
    e.sup = 1'b1;
    case (f)
      11'h020, 11'h021: begin
        e.r = 32'(ua + ub);
        e.c = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
        sr  = sa + sb;
        e.v = (f == 11'h020) && ((sr > SMAX) || (sr < SMIN));
      end
      11'h022, 11'h023: begin
        e.r = 32'(ua - ub);
        e.c = ua < ub;
        sr  = sa - sb;
        e.v = (f == 11'h022) && ((sr > SMAX) || (sr < SMIN));
      end
      11'h024: e.r = a & b;
      11'h025: e.r = a | b;
      11'h026: e.r = a ^ b;
      11'h027: e.r = ~(a | b);
      11'h02A: e.r = (sa < sb) ? 32'd1 : 32'd0;
      11'h02B: e.r = (ua < ub) ? 32'd1 : 32'd0;
      11'h004: e.r = 32'(ua << sh);
      11'h006: e.r = 32'(ua >> sh);
      11'h007: e.r = 32'(sa >>> sh);
      default: e.sup = 1'b0;
    endcase
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
    return (x == CMAX) ? x : x + 1'b1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [10:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] o, input logic c, input logic v, input logic z,
                       input logic vld);
    op = f; in0 = a; in1 = b; dut_out = o;
    dut_carryout = c; dut_overflow = v; dut_zero = z; in_valid = vld;
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // One transaction, then verify err_pulse lands exactly two edges after acceptance, for one cycle.
  task automatic run_txn(input logic [10:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] o, input logic c, input logic v, input logic z,
                         input logic exp_err);
    @(negedge clk); drive(f, a, b, o, c, v, z, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); check_eq("pulse_early", 32'(err_pulse), 32'd0);
    @(negedge clk); check_eq("pulse", 32'(err_pulse), 32'(exp_err));
    @(negedge clk); check_eq("pulse_len", 32'(err_pulse), 32'd0);
  endtask

  logic [10:0]   ops [13];
  pend_t         q [$];
  pend_t         p, n;
  exp_t          e;
  logic [31:0]   o;
  logic          c, v, z;
  logic [CW-1:0] m_chk, m_err, m_uns;
  logic          m_fv;
  pend_t         m_cap;

  initial begin
    ops = '{11'h020, 11'h021, 11'h022, 11'h023, 11'h024, 11'h025, 11'h026,
            11'h027, 11'h02A, 11'h02B, 11'h004, 11'h006, 11'h007};

    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_chk", 32'(check_count), 32'd0);
    check_eq("rst_fail_valid", 32'(fail_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", 32'(busy), 32'd0);

    // transactions in IDLE are ignored
    run_txn(11'h024, 32'h1, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("idle_ignored", 32'(err_count), 32'd0);

    do_start();
    check_eq("run_busy", 32'(busy), 32'd1);

    run_txn(11'h020, 32'h7fffffff, 32'h70000001, 32'hf0000000, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("add_ovf_chk", 32'(check_count), 32'd1);
    check_eq("add_ovf_err", 32'(err_count), 32'd0);

    run_txn(11'h022, 32'hffffffff, 32'hffffffff, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_txn(11'h022, 32'hffffffff, 32'hffffffff, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("sub_zero_err", 32'(err_count), 32'd1);
    check_eq("sub_zero_chk", 32'(check_count), 32'd3);
    check_eq("sub_zero_fexp", fail_exp, 32'h0);
    check_eq("sub_zero_fop", 32'(fail_op), 32'h022);
    check_eq("sub_zero_fv", 32'(fail_valid), 32'd1);

    do_start();
    check_eq("start_clr_err", 32'(err_count), 32'd0);
    check_eq("start_clr_fv", 32'(fail_valid), 32'd0);
    run_txn(11'h3ff, $urandom, $urandom, $urandom, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("unsup_cnt", 32'(unsup_count), 32'd1);
    check_eq("unsup_chk", 32'(check_count), 32'd0);

    run_txn(11'h02A, 32'hf0001231, 32'h7ac34545, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_txn(11'h02B, 32'hf0001231, 32'h7ac34545, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("slt_err", 32'(err_count), 32'd0);
    check_eq("slt_chk", 32'(check_count), 32'd2);

    // randomized back-to-back traffic; counters are narrow so saturation is exercised
    do_start();
    m_chk = '0; m_err = '0; m_uns = '0; m_fv = 1'b0; m_cap = '0;
    for (int i = 0; i < 303; i++) begin
      @(negedge clk);
      if (q.size() == 3) begin
        p = q.pop_front();
        check_eq("r_pulse", 32'(err_pulse), 32'(p.vld & p.sup & p.mis));
        if (p.vld) begin
          if (p.sup) m_chk = sat_inc(m_chk);
          else       m_uns = sat_inc(m_uns);
          if (p.sup && p.mis) begin
            m_err = sat_inc(m_err);
            if (!m_fv) begin
              m_fv  = 1'b1;
              m_cap = p;
            end
          end
        end
        check_eq("r_chk", 32'(check_count), 32'(m_chk));
        check_eq("r_err", 32'(err_count), 32'(m_err));
        check_eq("r_uns", 32'(unsup_count), 32'(m_uns));
      end
      n = '0;
      n.vld = (i < 300) && ($urandom_range(0, 3) != 0);
      n.f   = ($urandom_range(0, 7) == 0) ? 11'($urandom) : ops[$urandom_range(0, 12)];
      n.a   = $urandom;
      n.b   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      if ($urandom_range(0, 7) == 0) n.b = n.a;
      e = model(n.f, n.a, n.b);
      o = e.r; c = e.c; v = e.v; z = e.z;
      case ($urandom_range(0, 7))
        0: begin o = o ^ (32'd1 << $urandom_range(0, 31)); n.mis = 1'b1; end
        1: begin c = ~c; n.mis = 1'b1; end
        2: begin v = ~v; n.mis = 1'b1; end
        3: begin z = ~z; n.mis = 1'b1; end
        default: ;
      endcase
      n.sup = e.sup;
      n.got = o;
      n.exp = e.r;
      drive(n.f, n.a, n.b, o, c, v, z, n.vld);
      q.push_back(n);
    end
    in_valid = 1'b0;
    q.delete();
    check_eq("r_fv", 32'(fail_valid), 32'(m_fv));
    check_eq("r_fop", 32'(fail_op), 32'(m_cap.f));
    check_eq("r_fin0", fail_in0, m_cap.a);
    check_eq("r_fin1", fail_in1, m_cap.b);
    check_eq("r_fgot", fail_got, m_cap.got);
    check_eq("r_fexp", fail_exp, m_cap.exp);

    // halt on first error, then further traffic is ignored
    do_start();
    stop_on_err = 1'b1;
    run_txn(11'h007, 32'hffffffff, 32'h3, 32'h1fffffff, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("sra_halted", 32'(halted), 32'd1);
    check_eq("sra_busy", 32'(busy), 32'd0);
    check_eq("sra_fexp", fail_exp, 32'hffffffff);
    check_eq("sra_fgot", fail_got, 32'h1fffffff);
    check_eq("sra_fin1", fail_in1, 32'h3);
    run_txn(11'h024, 32'hff, 32'hff, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("halt_ign_err", 32'(err_count), 32'd1);
    check_eq("halt_ign_chk", 32'(check_count), 32'd1);
    do_start();
    stop_on_err = 1'b0;
    check_eq("restart_busy", 32'(busy), 32'd1);
    check_eq("restart_err", 32'(err_count), 32'd0);

    // two mismatches, then reset with a third transaction in flight
    run_txn(11'h024, 32'hff00ff00, 32'h0f0f0f0f, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_txn(11'h025, 32'hff00ff00, 32'h0f0f0f0f, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("pre_rst_err", 32'(err_count), 32'd2);
    @(negedge clk); drive(11'h026, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk); in_valid = 1'b0; rst = 1'b1;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_err", 32'(err_count), 32'd0);
    check_eq("arst_chk", 32'(check_count), 32'd0);
    check_eq("arst_fv", 32'(fail_valid), 32'd0);
    check_eq("arst_fexp", fail_exp, 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("post_rst_pulse", 32'(err_pulse), 32'd0);
      check_eq("post_rst_busy", 32'(busy), 32'd0);
    end
    check_eq("post_rst_err", 32'(err_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
